// File: rtl/sipo_rx_pkg.sv
// sipo_rx_pkg
//   Shared constants for the serial-in / parallel-out receiver slice.
//   Holds the default word geometry so the top and the shift core agree
//   on their parameter defaults.
package sipo_rx_pkg;

    // Default word width and bit order of the piso/sipo link.
    localparam int SIPO_WIDTH_DEF     = 4;
    localparam bit SIPO_MSB_FIRST_DEF = 1'b0;

endpackage : sipo_rx_pkg

// File: rtl/sipo_shift_core.sv
// sipo_shift_core
//   Shift register plus bit counter for the SIPO receiver. Samples din_i on
//   every enabled clock, and flags the completing bit of each word.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   enable_i     din_i carries a valid serial bit this cycle
//   din_i        serial data bit
//   clear_i      synchronous abort of the partial word (wins over enable_i)
//   word_o       assembled word including the bit sampled this cycle
//   word_done_o  single-cycle strobe: word_o is complete on this edge
//   bit_cnt_o    bits of the current partial word received so far
module sipo_shift_core
    import sipo_rx_pkg::*;
#(
    parameter int WIDTH     = SIPO_WIDTH_DEF,
    parameter bit MSB_FIRST = SIPO_MSB_FIRST_DEF,
    localparam int CW       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic             din_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] word_o,
    output logic             word_done_o,
    output logic [CW-1:0]    bit_cnt_o
);

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        if (clear_i) begin
            shreg_d = '0;
            cnt_d   = '0;
        end else if (enable_i) begin
            if (MSB_FIRST) begin
                shreg_d = {shreg_q[WIDTH-2:0], din_i};
            end else begin
                shreg_d = {din_i, shreg_q[WIDTH-1:1]};
            end
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                done  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // The word is taken from the next-state value so that the completing bit
    // is included; the top registers it on the same edge.
    assign word_o      = shreg_d;
    assign word_done_o = done;
    assign bit_cnt_o   = cnt_q;

endmodule : sipo_shift_core

// File: rtl/sipo_rx.sv
// sipo_rx
//   Serial-in, parallel-out receiver: receive end of the piso serial link.
//   Assembles WIDTH bits into a word and offers it on a valid/ready port
//   through a one-word holding register, so reception continues while the
//   consumer stalls. A word completed while the holding register is full and
//   not being consumed is dropped and sets the sticky overrun flag.
//
// Ports
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   enable    din holds a valid serial bit this cycle
//   din       serial data bit
//   clear     synchronous abort: drops partial word, clears overrun
//   data_out  received word (holding register)
//   valid     data_out holds an unconsumed word
//   ready     consumer accepts data_out when valid && ready
//   overrun   sticky: a completed word was dropped
//   bit_cnt   bits of the current partial word received so far
module sipo_rx
    import sipo_rx_pkg::*;
#(
    parameter int WIDTH     = SIPO_WIDTH_DEF,   // must be >= 2
    parameter bit MSB_FIRST = SIPO_MSB_FIRST_DEF,
    localparam int CW       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             din,
    input  logic             clear,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    input  logic             ready,
    output logic             overrun,
    output logic [CW-1:0]    bit_cnt
);

    logic [WIDTH-1:0] word;
    logic             word_done;

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .enable_i    (enable),
        .din_i       (din),
        .clear_i     (clear),
        .word_o      (word),
        .word_done_o (word_done),
        .bit_cnt_o   (bit_cnt)
    );

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        // A slot is free if empty or being emptied on this very edge, which
        // lets back-to-back words stream with ready tied high.
        if (word_done) begin
            if (!valid_q || ready) begin
                data_d  = word;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        // word_done is never raised together with clear, so this cannot
        // mask an overrun raised on the same edge.
        if (clear) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_out = data_q;
    assign valid    = valid_q;
    assign overrun  = overrun_q;

endmodule : sipo_rx

// File: tb/tb_sipo_rx.sv
// tb_sipo_rx
//   Directed bench for sipo_rx. Two instances share the stimulus: one with
//   LSB-first order, one with MSB-first order.
`timescale 1ns/1ps
module tb_sipo_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       din;
    logic       clear;
    logic       ready;

    logic [3:0] data_lsb, data_msb;
    logic       valid_lsb, valid_msb;
    logic       ovr_lsb, ovr_msb;
    logic [1:0] cnt_lsb, cnt_msb;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .din      (din),
        .clear    (clear),
        .data_out (data_lsb),
        .valid    (valid_lsb),
        .ready    (ready),
        .overrun  (ovr_lsb),
        .bit_cnt  (cnt_lsb)
    );

    sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .din      (din),
        .clear    (clear),
        .data_out (data_msb),
        .valid    (valid_msb),
        .ready    (ready),
        .overrun  (ovr_msb),
        .bit_cnt  (cnt_msb)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        enable = 1'b1;
        din    = b;
        tick();
        enable = 1'b0;
        din    = 1'b0;
    endtask

    // Bits in transmission order (b0 sent first).
    task automatic send_word(input logic b0, input logic b1, input logic b2, input logic b3);
        send_bit(b0);
        send_bit(b1);
        send_bit(b2);
        send_bit(b3);
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        din    = 1'b0;
        clear  = 1'b0;
        ready  = 1'b1;
        #12;
        check_val("rst_data",    data_lsb,  4'h0);
        check_val("rst_valid",   valid_lsb, 1'b0);
        check_val("rst_overrun", ovr_lsb,   1'b0);
        check_val("rst_cnt",     cnt_lsb,   2'd0);
        rst = 1'b0;
        tick();

        // 1/2: 1,0,1,1 back to back, ready high
        send_word(1, 0, 1, 1);
        check_val("t1_data_lsb",  data_lsb,  4'hD);
        check_val("t1_valid",     valid_lsb, 1'b1);
        check_val("t1_overrun",   ovr_lsb,   1'b0);
        check_val("t2_data_msb",  data_msb,  4'hB);
        check_val("t2_valid_msb", valid_msb, 1'b1);
        tick();
        check_val("t1_valid_one_cycle", valid_lsb, 1'b0);

        // 2: same word with 3 idle cycles between bits
        send_bit(1); check_val("t2_cnt1", cnt_lsb, 2'd1);
        repeat (3) tick();
        check_val("t2_gap_cnt", cnt_lsb, 2'd1);
        send_bit(0); check_val("t2_cnt2", cnt_lsb, 2'd2);
        repeat (3) tick();
        send_bit(1); check_val("t2_cnt3", cnt_lsb, 2'd3);
        check_val("t2_no_early_valid", valid_lsb, 1'b0);
        repeat (3) tick();
        send_bit(1); check_val("t2_cnt0", cnt_lsb, 2'd0);
        check_val("t2_gap_data", data_lsb, 4'hD);
        check_val("t2_gap_valid", valid_lsb, 1'b1);
        tick();

        // 3: stall, 5 then A -> A dropped, overrun sticky
        ready = 1'b0;
        send_word(1, 0, 1, 0);
        check_val("t3_data5",  data_lsb,  4'h5);
        check_val("t3_valid5", valid_lsb, 1'b1);
        check_val("t3_ovr0",   ovr_lsb,   1'b0);
        send_word(0, 1, 0, 1);
        check_val("t3_data_kept", data_lsb,  4'h5);
        check_val("t3_valid_kept", valid_lsb, 1'b1);
        check_val("t3_ovr1",      ovr_lsb,   1'b1);
        ready = 1'b1;
        tick();
        check_val("t3_valid_fall", valid_lsb, 1'b0);
        check_val("t3_ovr_sticky", ovr_lsb,   1'b1);
        repeat (2) tick();
        check_val("t3_ovr_sticky2", ovr_lsb, 1'b1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_val("t3_ovr_cleared", ovr_lsb, 1'b0);

        // 4: 3 pending, ready rises with last bit of C
        ready = 1'b0;
        send_word(1, 1, 0, 0);
        check_val("t4_data3", data_lsb, 4'h3);
        send_bit(0);
        send_bit(0);
        send_bit(1);
        ready = 1'b1;
        send_bit(1);
        check_val("t4_dataC",  data_lsb,  4'hC);
        check_val("t4_validC", valid_lsb, 1'b1);
        check_val("t4_ovr0",   ovr_lsb,   1'b0);
        tick();
        check_val("t4_consumed", valid_lsb, 1'b0);

        // clear with a pending word leaves the holding register alone
        ready = 1'b0;
        send_word(0, 1, 1, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_val("clr_keep_valid", valid_lsb, 1'b1);
        check_val("clr_keep_data",  data_lsb,  4'h6);
        ready = 1'b1;
        tick();

        // 5: async reset mid-word
        send_bit(1);
        send_bit(1);
        check_val("t5_cnt_before", cnt_lsb, 2'd2);
        #2 rst = 1'b1;
        #1;
        check_val("t5_rst_data",  data_lsb,  4'h0);
        check_val("t5_rst_cnt",   cnt_lsb,   2'd0);
        check_val("t5_rst_valid", valid_lsb, 1'b0);
        check_val("t5_rst_ovr",   ovr_lsb,   1'b0);
        #3 rst = 1'b0;
        tick();
        check_val("t5_no_valid_after_rst", valid_lsb, 1'b0);
        send_bit(1); send_bit(1); send_bit(1);
        check_val("t5_no_early", valid_lsb, 1'b0);
        send_bit(1);
        check_val("t5_dataF",  data_lsb,  4'hF);
        check_val("t5_validF", valid_lsb, 1'b1);
        tick();

        // 6: clear collides with completing bit
        send_bit(1); send_bit(1); send_bit(1);
        enable = 1'b1;
        din    = 1'b1;
        clear  = 1'b1;
        tick();
        enable = 1'b0;
        clear  = 1'b0;
        check_val("t6_no_valid", valid_lsb, 1'b0);
        check_val("t6_cnt0",     cnt_lsb,   2'd0);
        check_val("t6_data_old", data_lsb,  4'hF);
        send_word(0, 1, 0, 0);
        check_val("t6_data2",     data_lsb,  4'h2);
        check_val("t6_valid2",    valid_lsb, 1'b1);
        check_val("t6_data_msb4", data_msb,  4'h4);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected finish before 100000ns");
        $fatal(1);
    end

endmodule : tb_sipo_rx

// File: doc/sipo_rx.md
Name: sipo_rx

Overview:
Serial-in, parallel-out receiver. It is the receive end of the team's piso serial link: one bit per enable-qualified clock, LSB first by default. It assembles WIDTH bits into a word and presents the word on a valid/ready output port. A one-word holding register sits between the shifter and the consumer, so reception continues while the consumer stalls. A sticky flag reports overrun.

Parameters:
WIDTH, 4, bits per word; must be at least 2.
MSB_FIRST, 0, 0 means the first received bit lands in data_out[0]; 1 means it lands in data_out[WIDTH-1].

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  reset, asynchronous, active-high.
enable  input  1  din holds a valid serial bit this cycle.
din  input  1  serial data bit.
clear  input  1  synchronous abort: discards the partial word and clears overrun.
data_out  output  WIDTH  received word (holding register).
valid  output  1  data_out holds an unconsumed word.
ready  input  1  consumer accepts data_out when valid && ready.
overrun  output  1  sticky: a completed word was dropped.
bit_cnt  output  clog2(WIDTH)  bits of the current partial word received so far.

Behaviour:
- Reset (asynchronous, any time, including mid-word): shift register 0, bit_cnt 0, data_out 0, valid 0, overrun 0. A partial word is lost; no valid pulse follows reset release.
- Sampling: on a clk edge with enable=1 and clear=0, din is shifted in and bit_cnt increments. With enable=0, nothing changes. Gaps of any length between enabled bits are legal.
- Shift direction:
  - MSB_FIRST=0: shreg <= {din, shreg[WIDTH-1:1]}.
  - MSB_FIRST=1: shreg <= {shreg[WIDTH-2:0], din}.
- Word completion: an enabled bit with bit_cnt == WIDTH-1.
  - The assembled word is the shifter contents including that bit.
  - bit_cnt wraps to 0 on the same edge.
- Latency: data_out and valid update on the same edge that samples the last bit. valid is therefore seen high in the cycle after the final enable cycle.
- Handshake:
  - valid stays high and data_out stays stable until a cycle with valid && ready; valid falls on that edge.
  - ready is ignored when valid=0. ready may be tied high.
- Completion while the holding register is empty, or is being consumed on the same edge (valid && ready): the new word loads and valid is 1 after the edge. No bubble, no overrun.
- Completion while valid && !ready: the new word is dropped, data_out is kept, and overrun is set to 1. overrun stays 1 until clear or rst. Further receptions continue normally.
- clear:
  - Has priority over enable in the same cycle; that bit is discarded.
  - Zeroes the shifter and bit_cnt, and clears overrun.
  - Leaves data_out and valid untouched; a pending word can still be consumed.
- Simultaneous clear and a completing bit: clear wins, and no word is produced.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- No shared-package typedefs are needed. The counter width is clog2(WIDTH), computed locally.
- One natural sub-module: sipo_shift_core, containing the shifter plus bit counter, with outputs word and word_done (single-cycle).
- The top level holds the holding register, the valid/ready handshake and the overrun logic.

Test Plan:
1. WIDTH=4, MSB_FIRST=0, ready=1. Send bits 1,0,1,1 on 4 consecutive enable cycles -> data_out=4'hD; valid high exactly one cycle; overrun=0.
2. Same bits 1,0,1,1 with MSB_FIRST=1 -> data_out=4'hB. Then repeat case 1 with 3 idle cycles between each bit -> still 4'hD; bit_cnt steps 1,2,3,0.
3. ready=0. Send word 4'h5, then word 4'hA -> data_out stays 4'h5, valid stays 1, overrun=1. Raise ready -> valid falls after one cycle; overrun stays 1 until a clear pulse.
4. Word 4'h3 pending with ready=0. Raise ready on the same cycle the last bit of 4'hC is sampled -> 4'h3 accepted, data_out=4'hC, valid stays 1, overrun=0.
5. Send 2 bits, then assert rst asynchronously between edges -> all outputs 0 immediately. Then send 1,1,1,1 -> data_out=4'hF with no stale bits.
6. Send 3 bits, then clear together with enable on the 4th bit -> no valid, bit_cnt=0. Then send 0,1,0,0 -> data_out=4'h2.
